// File: rtl/reg_hazard_gate_if.sv
// Handshake and tracker-status bundle for reg_hazard_gate.
// master: upstream decode / tracker / register read side; slave: the gate.
interface reg_hazard_gate_if #(
  parameter int unsigned TAG_WIDTH = 16
);
  logic                 InstValid;
  logic                 InstReady;
  logic [TAG_WIDTH-1:0] InstTag;
  logic [3:0]           InstAAddress;
  logic                 InstReadsA;
  logic                 InstWritesA;
  logic                 InstMarkDirty;
  logic [3:0]           InstBAddress;
  logic                 InstReadsB;
  logic [15:0]          DirtyVector;
  logic [15:0]          ToBeWrittenVector;
  logic [15:0]          ToBeReadVector;
  logic                 DispatchValid;
  logic                 DispatchReady;
  logic [TAG_WIDTH-1:0] DispatchTag;
  logic                 ReadingFromA;
  logic                 WillBeWritingToA;
  logic                 MarkADirty;
  logic                 ReadingFromB;
  logic [3:0]           ReadAAddress;
  logic [3:0]           ReadBAddress;
  logic                 HazardStall;

  modport master (
    output InstValid, InstTag, InstAAddress, InstReadsA, InstWritesA, InstMarkDirty,
    output InstBAddress, InstReadsB, DirtyVector, ToBeWrittenVector, ToBeReadVector,
    output DispatchReady,
    input  InstReady, DispatchValid, DispatchTag, ReadingFromA, WillBeWritingToA,
    input  MarkADirty, ReadingFromB, ReadAAddress, ReadBAddress, HazardStall
  );

  modport slave (
    input  InstValid, InstTag, InstAAddress, InstReadsA, InstWritesA, InstMarkDirty,
    input  InstBAddress, InstReadsB, DirtyVector, ToBeWrittenVector, ToBeReadVector,
    input  DispatchReady,
    output InstReady, DispatchValid, DispatchTag, ReadingFromA, WillBeWritingToA,
    output MarkADirty, ReadingFromB, ReadAAddress, ReadBAddress, HazardStall
  );
endinterface

// File: rtl/reg_hazard_gate.sv
// Two-entry in-order holding buffer that releases an instruction to register read only when
// its operands are hazard-free. REG_HAZARD_STALL_COUNT_EN adds a saturating StallCount output.
module reg_hazard_gate #(
  parameter int unsigned TAG_WIDTH = 16
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        sync_rst,
  input  logic        Flush,
`ifdef REG_HAZARD_STALL_COUNT_EN
  output logic [15:0] StallCount,
`endif
  reg_hazard_gate_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [3:0]           a_addr;
    logic                 reads_a;
    logic                 writes_a;
    logic                 mark_dirty;
    logic [3:0]           b_addr;
    logic                 reads_b;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d, inst_e;
  logic   ready_q, ready_d;
  logic   head_valid, hazard, disp_valid, fire, accept;
  logic   raw_a, raw_b, waw_a, war_a, dirty_a;

  assign inst_e = '{tag:        bus.InstTag,
                    a_addr:     bus.InstAAddress,
                    reads_a:    bus.InstReadsA,
                    writes_a:   bus.InstWritesA,
                    mark_dirty: bus.InstMarkDirty,
                    b_addr:     bus.InstBAddress,
                    reads_b:    bus.InstReadsB};

  assign head_valid = (state_q != StEmpty);
  assign raw_a      = head_q.reads_a  && bus.ToBeWrittenVector[head_q.a_addr];
  assign raw_b      = head_q.reads_b  && bus.ToBeWrittenVector[head_q.b_addr];
  assign waw_a      = head_q.writes_a && bus.ToBeWrittenVector[head_q.a_addr];
  assign war_a      = head_q.writes_a && bus.ToBeReadVector[head_q.a_addr];
  assign dirty_a    = head_q.writes_a && head_q.mark_dirty && bus.DirtyVector[head_q.a_addr];
  assign hazard     = raw_a || raw_b || waw_a || war_a || dirty_a;

  assign disp_valid = clk_en && head_valid && !hazard;
  assign fire       = disp_valid && bus.DispatchReady;
  assign accept     = clk_en && bus.InstValid && ready_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clk_en) begin
      if (Flush) begin
        // Claims of a fire in this cycle still go out; only the buffer contents are dropped.
        state_d = StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              state_d = StOne;
              head_d  = inst_e;
            end
          end
          StOne: begin
            if (fire && accept) begin
              head_d = inst_e;
            end else if (fire) begin
              state_d = StEmpty;
            end else if (accept) begin
              tail_d  = inst_e;
              state_d = StFull;
            end
          end
          StFull: begin
            if (fire) begin
              head_d  = tail_q;
              state_d = StOne;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end
    ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  assign bus.InstReady        = ready_q;
  assign bus.DispatchValid    = disp_valid;
  assign bus.DispatchTag      = head_q.tag;
  assign bus.ReadAAddress     = head_q.a_addr;
  assign bus.ReadBAddress     = head_q.b_addr;
  assign bus.ReadingFromA     = fire && head_q.reads_a;
  assign bus.WillBeWritingToA = fire && head_q.writes_a;
  assign bus.MarkADirty       = fire && head_q.writes_a && head_q.mark_dirty;
  assign bus.ReadingFromB     = fire && head_q.reads_b;
  assign bus.HazardStall      = head_valid && hazard;

`ifdef REG_HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      stall_cnt_q <= '0;
    end else if (clk_en && bus.HazardStall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_hazard_gate.sv
// Directed self-checking bench for reg_hazard_gate; covers StallCount when
// REG_HAZARD_STALL_COUNT_EN is defined.
module tb_reg_hazard_gate;

  logic clk = 1'b0;
  logic clk_en, sync_rst, Flush;
  int   n_cmp = 0;
  int   n_err = 0;
`ifdef REG_HAZARD_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  reg_hazard_gate_if #(.TAG_WIDTH(16)) bus ();

  reg_hazard_gate #(.TAG_WIDTH(16)) dut (
    .clk        (clk),
    .clk_en     (clk_en),
    .sync_rst   (sync_rst),
    .Flush      (Flush),
`ifdef REG_HAZARD_STALL_COUNT_EN
    .StallCount (stall_count),
`endif
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  logic [3:0] claims;
  assign claims = {bus.ReadingFromA, bus.WillBeWritingToA, bus.MarkADirty, bus.ReadingFromB};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] tag, input logic [3:0] a, input logic ra,
                      input logic wa, input logic md, input logic [3:0] b, input logic rb);
    bus.InstValid     = 1'b1;
    bus.InstTag       = tag;
    bus.InstAAddress  = a;
    bus.InstReadsA    = ra;
    bus.InstWritesA   = wa;
    bus.InstMarkDirty = md;
    bus.InstBAddress  = b;
    bus.InstReadsB    = rb;
  endtask

  task automatic idle();
    bus.InstValid = 1'b0;
  endtask

  task automatic check_count(input string tag, input logic [15:0] exp);
`ifdef REG_HAZARD_STALL_COUNT_EN
    check(tag, stall_count, exp);
`endif
  endtask

  initial begin
    clk_en = 1'b1;
    sync_rst = 1'b1;
    Flush = 1'b0;
    bus.DirtyVector = '0;
    bus.ToBeWrittenVector = '0;
    bus.ToBeReadVector = '0;
    bus.DispatchReady = 1'b1;
    send(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    repeat (2) tick();
    sync_rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", bus.InstReady, 1);
    check("rst_dv", bus.DispatchValid, 0);
    check("rst_stall", bus.HazardStall, 0);
    check("rst_claims", claims, 4'b0000);
    check_count("rst_count", 16'd0);

    // Single hazard-free instruction: ReadsA r3, ReadsB r5
    tick();
    send(16'h0011, 4'd3, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
    @(negedge clk);
    check("t1_dv_before_accept", bus.DispatchValid, 0);
    tick();
    idle();
    @(negedge clk);
    check("t1_dv", bus.DispatchValid, 1);
    check("t1_claims", claims, 4'b1001);
    check("t1_addr_a", bus.ReadAAddress, 3);
    check("t1_addr_b", bus.ReadBAddress, 5);
    check("t1_tag", bus.DispatchTag, 16'h0011);
    check("t1_ready", bus.InstReady, 1);
    tick();
    @(negedge clk);
    check("t1_drained", bus.DispatchValid, 0);

    // WAR on r7 for 4 cycles
    tick();
    bus.ToBeReadVector = 16'h0080;
    send(16'h0022, 4'd7, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_stall", bus.HazardStall, 1);
      check("t2_no_claim", claims, 4'b0000);
      tick();
    end
    bus.ToBeReadVector = '0;
    @(negedge clk);
    check("t2_fire_dv", bus.DispatchValid, 1);
    check("t2_fire_claims", claims, 4'b0100);
    check("t2_stall_clear", bus.HazardStall, 0);
    check_count("t2_count", 16'd4);
    tick();

    // RAW on r2 fills the buffer; third instruction waits upstream
    bus.ToBeWrittenVector = 16'h0004;
    send(16'h0031, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    tick();
    send(16'h0032, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    send(16'h0033, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    check("t3_full_ready", bus.InstReady, 0);
    check("t3_stall", bus.HazardStall, 1);
    check("t3_head_tag", bus.DispatchTag, 16'h0031);
    tick();
    bus.ToBeWrittenVector = '0;
    @(negedge clk);
    check("t3_still_full", bus.InstReady, 0);
    check("t3_head_dv", bus.DispatchValid, 1);
    check("t3_head_tag2", bus.DispatchTag, 16'h0031);
    check("t3_head_claims", claims, 4'b0001);
    tick();
    @(negedge clk);
    check("t3_tail_tag", bus.DispatchTag, 16'h0032);
    check("t3_tail_dv", bus.DispatchValid, 1);
    check("t3_tail_claims", claims, 4'b1000);
    check("t3_ready_back", bus.InstReady, 1);
    tick();
    idle();
    @(negedge clk);
    check("t3_third_tag", bus.DispatchTag, 16'h0033);
    check("t3_third_dv", bus.DispatchValid, 1);
    tick();
    @(negedge clk);
    check("t3_drained", bus.DispatchValid, 0);

    // Backpressure: DispatchReady low for 3 cycles
    bus.DispatchReady = 1'b0;
    send(16'h0044, 4'd9, 1'b0, 1'b1, 1'b1, 4'd10, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_dv_hold", bus.DispatchValid, 1);
      check("t4_tag_hold", bus.DispatchTag, 16'h0044);
      check("t4_no_claim", claims, 4'b0000);
      tick();
    end
    bus.DispatchReady = 1'b1;
    @(negedge clk);
    check("t4_claims", claims, 4'b0111);
    check("t4_addr_a", bus.ReadAAddress, 9);
    tick();
    @(negedge clk);
    check("t4_one_pulse", claims, 4'b0000);
    check("t4_drained", bus.DispatchValid, 0);

    // Dirty hazard on r14
    bus.DirtyVector = 16'h4000;
    send(16'h004E, 4'd14, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t5_dirty_stall", bus.HazardStall, 1);
    check("t5_dirty_dv", bus.DispatchValid, 0);
    tick();
    bus.DirtyVector = '0;
    @(negedge clk);
    check("t5_dirty_claims", claims, 4'b0110);
    tick();

    // clk_en low holds the head and suppresses dispatch
    send(16'h005C, 4'd6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    clk_en = 1'b0;
    @(negedge clk);
    check("t6_gated_dv", bus.DispatchValid, 0);
    check("t6_gated_claims", claims, 4'b0000);
    tick();
    clk_en = 1'b1;
    @(negedge clk);
    check("t6_resume_tag", bus.DispatchTag, 16'h005C);
    check("t6_resume_claims", claims, 4'b1000);
    tick();

    // Flush a full buffer with an instruction offered in the same cycle
    bus.ToBeWrittenVector = 16'h0001;
    send(16'h0061, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    send(16'h0062, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    send(16'h0063, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    Flush = 1'b1;
    @(negedge clk);
    check("t7_full", bus.InstReady, 0);
    tick();
    Flush = 1'b0;
    idle();
    @(negedge clk);
    check("t7_empty_dv", bus.DispatchValid, 0);
    check("t7_empty_stall", bus.HazardStall, 0);
    check("t7_ready", bus.InstReady, 1);
    bus.ToBeWrittenVector = '0;
    tick();
    @(negedge clk);
    check("t7_nothing_left", bus.DispatchValid, 0);

    // Reset while full and stalled
    bus.ToBeWrittenVector = 16'h0001;
    send(16'h0071, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    send(16'h0072, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t8_stalled", bus.HazardStall, 1);
    tick();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    @(negedge clk);
    check("t8_ready", bus.InstReady, 1);
    check("t8_dv", bus.DispatchValid, 0);
    check("t8_stall", bus.HazardStall, 0);
    check("t8_claims", claims, 4'b0000);
    check_count("t8_count", 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
